// File: rtl/grid_claim_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grid_claim_arbiter
// Purpose  : Round-robin arbiter that serialises READ / CLAIM / RELEASE
//            operations from N_REQ placer engines onto one grid RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module grid_claim_arbiter #(
   parameter int          N_REQ      = 4,
   parameter int          GRID_CELLS = 144,
   parameter logic [31:0] EMPTY      = 32'hFFFF_FFFF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    i_req,
   input  logic [2*N_REQ-1:0]  i_op,
   input  logic [32*N_REQ-1:0] i_addr,
   input  logic [32*N_REQ-1:0] i_id,
   output logic [N_REQ-1:0]    o_done,
   output logic                o_ok,
   output logic [31:0]         o_rdata,
   output logic                o_busy,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic [31:0]         o_mem_addr,
   output logic [31:0]         o_mem_din,
   input  logic [31:0]         i_mem_dout,
   output logic [31:0]         o_n_grants,
   output logic [31:0]         o_n_conflicts
);

   localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_RD   = 3'd1;
   localparam logic [2:0] c_ST_WAIT = 3'd2;
   localparam logic [2:0] c_ST_CHK  = 3'd3;
   localparam logic [2:0] c_ST_WR   = 3'd4;
   localparam logic [2:0] c_ST_RESP = 3'd5;

   localparam logic [1:0] c_OP_READ    = 2'b00;
   localparam logic [1:0] c_OP_CLAIM   = 2'b01;
   localparam logic [1:0] c_OP_RELEASE = 2'b10;
   localparam logic [1:0] c_OP_RSV     = 2'b11;

   logic [2:0]       r_state;
   logic [c_PW-1:0]  r_ptr;
   logic [c_PW-1:0]  r_win;
   logic [1:0]       r_op;
   logic [31:0]      r_id;
   logic [N_REQ-1:0] r_done;
   logic             r_ok;
   logic [31:0]      r_rdata;
   logic             r_mem_read;
   logic             r_mem_write;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_mem_din;
   logic [31:0]      r_n_grants;
   logic [31:0]      r_n_conflicts;

   logic             w_hi_any;
   logic [c_PW-1:0]  w_hi;
   logic             w_any;
   logic [c_PW-1:0]  w_lo;
   logic [c_PW-1:0]  w_win;
   logic [c_PW-1:0]  w_next_ptr;
   logic [1:0]       w_op;
   logic [31:0]      w_addr;
   logic [31:0]      w_id;
   logic             w_bad;
   logic [N_REQ-1:0] w_win_oh;
   logic [N_REQ-1:0] w_cur_oh;

   // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_hi_any = 1'b0;
      w_hi     = '0;
      w_any    = 1'b0;
      w_lo     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            w_any = 1'b1;
            w_lo  = c_PW'(k);
            if (c_PW'(k) >= r_ptr) begin
               w_hi_any = 1'b1;
               w_hi     = c_PW'(k);
            end
         end
      end
      w_win = w_hi_any ? w_hi : w_lo;
   end

   always_comb begin
      w_op   = '0;
      w_addr = '0;
      w_id   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_win == c_PW'(k)) begin
            w_op   = i_op[2*k +: 2];
            w_addr = i_addr[32*k +: 32];
            w_id   = i_id[32*k +: 32];
         end
      end
   end

   assign w_bad      = ($signed(w_addr) < 0) || ($signed(w_addr) >= GRID_CELLS) ||
                       (w_op == c_OP_RSV);
   assign w_next_ptr = (w_win == c_PW'(N_REQ - 1)) ? '0 : w_win + c_PW'(1);
   assign w_win_oh   = N_REQ'(1) << w_win;
   assign w_cur_oh   = N_REQ'(1) << r_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= c_ST_IDLE;
         r_ptr         <= '0;
         r_win         <= '0;
         r_op          <= '0;
         r_id          <= '0;
         r_done        <= '0;
         r_ok          <= 1'b0;
         r_rdata       <= '0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_din     <= '0;
         r_n_grants    <= '0;
         r_n_conflicts <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_any) begin
                  r_win <= w_win;
                  r_op  <= w_op;
                  r_id  <= w_id;
                  r_ptr <= w_next_ptr;
                  if (w_bad) begin
                     r_state <= c_ST_RESP;
                     r_done  <= w_win_oh;
                     r_ok    <= 1'b0;
                     r_rdata <= '0;
                  end else begin
                     r_state    <= c_ST_RD;
                     r_mem_read <= 1'b1;
                     r_mem_addr <= w_addr;
                  end
               end
            end
            c_ST_RD: begin
               r_mem_read <= 1'b0;
               r_state    <= c_ST_WAIT;
            end
            c_ST_WAIT: begin
               r_state <= c_ST_CHK;
            end
            c_ST_CHK: begin
               r_rdata <= i_mem_dout;
               r_ok    <= 1'b0;
               r_state <= c_ST_RESP;
               r_done  <= w_cur_oh;
               case (r_op)
                  c_OP_READ: begin
                     r_ok <= 1'b1;
                  end
                  c_OP_CLAIM: begin
                     if (i_mem_dout == EMPTY) begin
                        r_state     <= c_ST_WR;
                        r_done      <= '0;
                        r_mem_write <= 1'b1;
                        r_mem_din   <= r_id;
                     end else begin
                        r_n_conflicts <= r_n_conflicts + 32'd1;
                     end
                  end
                  c_OP_RELEASE: begin
                     if (i_mem_dout == r_id) begin
                        r_state     <= c_ST_WR;
                        r_done      <= '0;
                        r_mem_write <= 1'b1;
                        r_mem_din   <= EMPTY;
                     end
                  end
                  default: begin
                     r_ok <= 1'b0;
                  end
               endcase
            end
            c_ST_WR: begin
               r_mem_write <= 1'b0;
               r_ok        <= 1'b1;
               r_done      <= w_cur_oh;
               r_state     <= c_ST_RESP;
            end
            c_ST_RESP: begin
               r_done     <= '0;
               r_ok       <= 1'b0;
               r_n_grants <= r_n_grants + 32'd1;
               r_state    <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign o_done        = r_done;
   assign o_ok          = r_ok;
   assign o_rdata       = r_rdata;
   assign o_busy        = (r_state != c_ST_IDLE);
   assign o_mem_read    = r_mem_read;
   assign o_mem_write   = r_mem_write;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_din     = r_mem_din;
   assign o_n_grants    = r_n_grants;
   assign o_n_conflicts = r_n_conflicts;

endmodule
`default_nettype wire

// File: doc/grid_claim_arbiter.md
GRID_CLAIM_ARBITER -- requirements
Module: grid_claim_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesting placer engines (2..8).
REQ-002 Parameter GRID_CELLS, default 144, number of grid RAM words (n*n); valid addresses 0..GRID_CELLS-1.
REQ-003 Parameter EMPTY, default -1 (32'hFFFFFFFF), grid value marking an unoccupied cell.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 req  input  N_REQ  per-requester request, held high until its done pulse.
REQ-007 op  input  2*N_REQ  per-requester opcode: 00 READ, 01 CLAIM, 10 RELEASE, 11 reserved.
REQ-008 addr  input  32*N_REQ  per-requester signed grid address (x*n+y).
REQ-009 id  input  32*N_REQ  per-requester node id written on CLAIM and compared on RELEASE.
REQ-010 done  output  N_REQ  one-cycle completion pulse to the served requester.
REQ-011 ok  output  1  operation result, valid only while any done bit is high.
REQ-012 rdata  output  32  grid word read, valid only while any done bit is high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mem_read, mem_write  output  1 each  grid RAM read/write strobes (one-cycle pulses).
REQ-015 mem_addr  output  32  grid RAM address; mem_din  output  32  write data.
REQ-016 mem_dout  input  32  grid RAM read data, valid two cycles after the mem_read cycle.
REQ-017 n_grants, n_conflicts  output  32 each  count of served requests and of failed CLAIMs.

Function
REQ-018 FSM states: IDLE, RD, WAIT, CHK, WR, RESP; exactly one operation in flight.
REQ-019 IDLE: if any req bit is high, latch the round-robin winner's index, op, addr, and id. Then go to RD, except for out-of-range address or op 11, which go directly to RESP with ok=0 and rdata=0.
REQ-020 Round-robin: the search starts at index ptr, and ptr becomes winner+1 mod N_REQ on each grant; ptr is 0 after reset.
REQ-021 Out-of-range: addr<0 or addr>=GRID_CELLS; no mem_read/mem_write is issued.
REQ-022 RD: mem_read=1, mem_addr=latched addr; next WAIT; WAIT: next CHK.
REQ-023 CHK: capture mem_dout into rdata. Then branch by op:
  - READ: go to RESP, ok=1.
  - CLAIM: if mem_dout==EMPTY, go to WR with mem_din=id; else go to RESP, ok=0, and increment n_conflicts.
  - RELEASE: if mem_dout==id, go to WR with mem_din=EMPTY; else go to RESP, ok=0.
REQ-024 WR: mem_write=1, mem_addr=latched addr; ok=1; next RESP.
REQ-025 RESP: done[winner]=1 for one cycle; increment n_grants; next IDLE.
REQ-026 Latency from the grant edge to the done pulse: successful CLAIM/RELEASE 5 cycles; READ or failed CLAIM/RELEASE 4 cycles; invalid request 1 cycle.
REQ-027 Back-to-back operation: a new grant may occur in the IDLE cycle directly after RESP; the minimum spacing between done pulses is therefore 2 cycles.
REQ-028 A req bit dropping mid-operation does not abort the operation; done is still pulsed.
REQ-029 A requester's req must be low in the cycle after its done pulse or it is re-arbitrated as a new request.
REQ-030 Simultaneous requests: only the winner is served; losers wait, with no starvation (each is served within N_REQ grants).
REQ-031 CLAIM read-check-write is atomic; no other request touches the grid between its RD and WR.
REQ-032 mem_read and mem_write are never high in the same cycle.
REQ-033 Counters wrap at 2^32.

Reset
REQ-034 reset low asynchronously forces IDLE, ptr=0, done=0, ok=0, rdata=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0, n_grants=0, n_conflicts=0.
REQ-035 Reset mid-operation abandons the operation with no done pulse; a write is issued only if the WR edge completed before reset.
REQ-036 Operation resumes on the first rising clk edge after reset returns high.

Verification
REQ-037 Cell 10 = EMPTY; req0 CLAIM addr 10 id 7 -> mem_write with addr 10, din 7; done[0] after 5 cycles, ok=1; n_grants=1.
REQ-038 Cell 10 = 7; req1 CLAIM addr 10 id 3 -> no write; done[1] with ok=0, rdata=7; n_conflicts=1.
REQ-039 req0..3 all raised together with ptr=0, each held until its done -> done order 0,1,2,3; ptr returns to 0.
REQ-040 req2 CLAIM addr 144 (GRID_CELLS=144), then addr -1 -> no mem strobes; done[2] one cycle after each grant, ok=0.
REQ-041 Cell 5 = 9; RELEASE id 4 -> ok=0, cell unchanged; RELEASE id 9 -> write of EMPTY, ok=1; READ -> rdata=32'hFFFFFFFF.
REQ-042 reset low during WAIT of a CLAIM -> no write, no done; all outputs at reset values immediately (asynchronous).
